// File: rtl/cdma_pkg.sv
// -----------------------------------------------------------------------------
// cdma_pkg
// Shared definitions for the two-user CDMA transmit scheduler:
//   - cdma_state_t   : scheduler FSM state encoding
//   - CODE_A_DEFAULT : default user-A Walsh code (MSB transmitted first)
//   - CODE_B_DEFAULT : default user-B Walsh code (MSB transmitted first)
//   - CHIPS_PER_BIT  : chips per data bit (Walsh code length)
//   - BITS_PER_USER  : data bits per user per frame
//   - chip_sum()     : maps two +/-1 chips to a 3-bit two's-complement level
// -----------------------------------------------------------------------------
package cdma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SPREAD = 2'd1,
      ST_DONE   = 2'd2
   } cdma_state_t;

   localparam logic [3:0] CODE_A_DEFAULT = 4'b1010;
   localparam logic [3:0] CODE_B_DEFAULT = 4'b1100;

   localparam int CHIPS_PER_BIT = 4;
   localparam int BITS_PER_USER = 2;

   // Chip value 1 means +1 and 0 means -1, so the sum is +2, 0 or -2.
   function automatic logic [2:0] chip_sum(input logic chip_a, input logic chip_b);
      logic [2:0] level;
      case ({chip_a, chip_b})
         2'b11:   level = 3'b010;
         2'b00:   level = 3'b110;
         default: level = 3'b000;
      endcase
      return level;
   endfunction

endpackage

// File: rtl/cdma_chip_timer.sv
// -----------------------------------------------------------------------------
// cdma_chip_timer
// Chip-rate divider. While en is high a 16-bit counter runs 0..CHIP_DIV-1 and
// wraps. chip_due is asserted one cycle before the counter reaches CHIP_DIV-1,
// so a registered chip output loaded on chip_due becomes visible exactly on
// the cycle the counter holds CHIP_DIV-1.
// Ports:
//   clk      : clock
//   srst     : synchronous active-high reset
//   clr      : clears the counter (asserted on the cycle a frame is accepted)
//   en       : counter runs while high
//   chip_due : next cycle is a chip strobe cycle
// -----------------------------------------------------------------------------
module cdma_chip_timer #(
   parameter int unsigned CHIP_DIV = 50000
) (
   input  logic clk,
   input  logic srst,
   input  logic clr,
   input  logic en,
   output logic chip_due
);

   localparam logic [15:0] COUNT_LAST = 16'(CHIP_DIV - 1);
   localparam logic [15:0] COUNT_PRE  = 16'(CHIP_DIV - 2);

   logic [15:0] count_reg;

   always_ff @(posedge clk) begin
      if (srst || clr) begin
         count_reg <= 16'd0;
      end else if (en) begin
         if (count_reg == COUNT_LAST) begin
            count_reg <= 16'd0;
         end else begin
            count_reg <= count_reg + 16'd1;
         end
      end
   end

   assign chip_due = en && (count_reg == COUNT_PRE);

endmodule

// File: rtl/cdma_tx_scheduler.sv
// -----------------------------------------------------------------------------
// cdma_tx_scheduler
// Two-user CDMA spreader. A 4-bit frame (two bits per user) is spread by each
// user's 4-chip Walsh code into 8 chips, one every CHIP_DIV clocks, and the two
// user chips are summed into a three-level transmit value.
// Ports:
//   CLOCK_50   : clock, rising edge
//   reset      : synchronous active-high reset
//   start      : frame request, honoured only while idle
//   auto_run   : chain a new frame after each completed frame
//   data       : payload, [1:0] user A, [3:2] user B, bit 0 of each pair first
//   busy       : frame in progress (SPREAD or DONE)
//   chip_valid : one-cycle strobe qualifying the chip outputs below
//   tx_level   : two's-complement sum of the user chips (+2, 0, -2)
//   chip_a     : user-A chip (1 = +1, 0 = -1)
//   chip_b     : user-B chip (1 = +1, 0 = -1)
//   bit_idx    : data bit being spread
//   chip_idx   : chip position in the code, 0 = MSB
//   done       : one-cycle strobe on frame completion
// -----------------------------------------------------------------------------
module cdma_tx_scheduler
   import cdma_pkg::*;
#(
   parameter int unsigned CHIP_DIV = 50000,
   parameter logic [3:0]  CODE_A   = CODE_A_DEFAULT,
   parameter logic [3:0]  CODE_B   = CODE_B_DEFAULT
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic       auto_run,
   input  logic [3:0] data,
   output logic       busy,
   output logic       chip_valid,
   output logic [2:0] tx_level,
   output logic       chip_a,
   output logic       chip_b,
   output logic       bit_idx,
   output logic [1:0] chip_idx,
   output logic       done
);

   cdma_state_t state_reg;
   logic [3:0]  frame_reg;
   logic [2:0]  chip_seq_reg;     // next chip to emit: {bit, chip}
   logic        busy_reg;
   logic        chip_valid_reg;
   logic [2:0]  tx_level_reg;
   logic        chip_a_reg;
   logic        chip_b_reg;
   logic        bit_idx_reg;
   logic [1:0]  chip_idx_reg;
   logic        done_reg;

   logic        chip_due;
   logic        timer_clr;
   logic        timer_en;
   logic        bit_sel;
   logic [1:0]  chip_sel;
   logic [1:0]  user_chip;        // [0] user A, [1] user B
   logic        last_chip_shown;

   // The divider restarts on every accept, whether from IDLE or chained from DONE.
   assign timer_en  = (state_reg == ST_SPREAD);
   assign timer_clr = ((state_reg == ST_IDLE) && start) ||
                      ((state_reg == ST_DONE) && auto_run);

   cdma_chip_timer #(
      .CHIP_DIV (CHIP_DIV)
   ) u_chip_timer (
      .clk      (CLOCK_50),
      .srst     (reset),
      .clr      (timer_clr),
      .en       (timer_en),
      .chip_due (chip_due)
   );

   assign bit_sel  = chip_seq_reg[2];
   assign chip_sel = chip_seq_reg[1:0];

   // A data 1 sends the code as-is, a data 0 sends it inverted.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_user
         localparam logic [3:0] USER_CODE = (gi == 0) ? CODE_A : CODE_B;
         logic [1:0] user_bits;
         assign user_bits     = frame_reg[2*gi +: 2];
         assign user_chip[gi] = ~(USER_CODE[2'd3 - chip_sel] ^ user_bits[bit_sel]);
      end
   endgenerate

   // The eighth chip is on the outputs; the frame closes on the following edge.
   assign last_chip_shown = chip_valid_reg &&
                            (bit_idx_reg  == 1'(BITS_PER_USER - 1)) &&
                            (chip_idx_reg == 2'(CHIPS_PER_BIT - 1));

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         frame_reg      <= 4'd0;
         chip_seq_reg   <= 3'd0;
         busy_reg       <= 1'b0;
         chip_valid_reg <= 1'b0;
         tx_level_reg   <= 3'd0;
         chip_a_reg     <= 1'b0;
         chip_b_reg     <= 1'b0;
         bit_idx_reg    <= 1'b0;
         chip_idx_reg   <= 2'd0;
         done_reg       <= 1'b0;
      end else begin
         chip_valid_reg <= 1'b0;
         done_reg       <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_reg    <= ST_SPREAD;
                  frame_reg    <= data;
                  chip_seq_reg <= 3'd0;
                  busy_reg     <= 1'b1;
               end
            end
            ST_SPREAD: begin
               if (chip_due) begin
                  chip_valid_reg <= 1'b1;
                  chip_a_reg     <= user_chip[0];
                  chip_b_reg     <= user_chip[1];
                  tx_level_reg   <= chip_sum(user_chip[0], user_chip[1]);
                  bit_idx_reg    <= bit_sel;
                  chip_idx_reg   <= chip_sel;
                  chip_seq_reg   <= chip_seq_reg + 3'd1;
               end
               if (last_chip_shown) begin
                  state_reg <= ST_DONE;
                  done_reg  <= 1'b1;
               end
            end
            ST_DONE: begin
               if (auto_run) begin
                  state_reg    <= ST_SPREAD;
                  frame_reg    <= data;
                  chip_seq_reg <= 3'd0;
               end else begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = busy_reg;
   assign chip_valid = chip_valid_reg;
   assign tx_level   = tx_level_reg;
   assign chip_a     = chip_a_reg;
   assign chip_b     = chip_b_reg;
   assign bit_idx    = bit_idx_reg;
   assign chip_idx   = chip_idx_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_cdma_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cdma_tx_scheduler
// Self-checking bench for cdma_tx_scheduler with CHIP_DIV=4 and default codes.
// Expected chips come from a +/-1 arithmetic model of the spreading rule.
// -----------------------------------------------------------------------------
module tb_cdma_tx_scheduler;

   localparam int         DIV    = 4;
   localparam logic [3:0] CODE_A = 4'b1010;
   localparam logic [3:0] CODE_B = 4'b1100;
   localparam int         FRAME_CYCLES = 8 * DIV + 1;

   logic       CLOCK_50 = 1'b0;
   logic       reset    = 1'b0;
   logic       start    = 1'b0;
   logic       auto_run = 1'b0;
   logic [3:0] data     = 4'd0;
   logic       busy;
   logic       chip_valid;
   logic [2:0] tx_level;
   logic       chip_a;
   logic       chip_b;
   logic       bit_idx;
   logic [1:0] chip_idx;
   logic       done;

   int total = 0;
   int bad   = 0;

   cdma_tx_scheduler #(
      .CHIP_DIV (DIV),
      .CODE_A   (CODE_A),
      .CODE_B   (CODE_B)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .start      (start),
      .auto_run   (auto_run),
      .data       (data),
      .busy       (busy),
      .chip_valid (chip_valid),
      .tx_level   (tx_level),
      .chip_a     (chip_a),
      .chip_b     (chip_b),
      .bit_idx    (bit_idx),
      .chip_idx   (chip_idx),
      .done       (done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   // +/-1 value of one user's chip: code chip times data symbol.
   function automatic int user_val(input logic [3:0] code, input int c, input logic dbit);
      int cv;
      cv = code[3 - c] ? 1 : -1;
      return cv * (dbit ? 1 : -1);
   endfunction

   // Called in the accept cycle N; walks cycles N+1 .. N+8*DIV+1 comparing
   // every cycle against the model, and returns the observed strobe sequence.
   task automatic check_frame(input string tag, input logic [3:0] d,
                              input logic [3:0] d_new, input int change_at,
                              input int auto_off_at, input bit keep_start,
                              output logic [23:0] lv_seq, output logic [7:0] a_seq);
      logic [7:0] hold;
      logic       want_valid;
      int         s, b, c, va, vb;
      lv_seq = '0;
      a_seq  = '0;
      hold   = '0;
      for (int k = 1; k <= FRAME_CYCLES; k++) begin
         step();
         if (k == 1 && !keep_start) start = 1'b0;
         if (k == change_at) data = d_new;
         if (k == auto_off_at) auto_run = 1'b0;
         want_valid = (k % DIV == 0) && (k / DIV >= 1) && (k / DIV <= 8);
         if (want_valid) begin
            s  = k / DIV - 1;
            b  = s / 4;
            c  = s % 4;
            va = user_val(CODE_A, c, d[b]);
            vb = user_val(CODE_B, c, d[2 + b]);
            hold = {(va > 0), (vb > 0), 3'(va + vb), 1'(b), 2'(c)};
            lv_seq[3*s +: 3] = tx_level;
            a_seq[s]         = chip_a;
         end
         total++;
         if (chip_valid !== want_valid) begin
            bad++;
            $display("FAIL %s chip_valid k=%0d got=%0b want=%0b", tag, k, chip_valid, want_valid);
         end
         total++;
         if (done !== (k == FRAME_CYCLES)) begin
            bad++;
            $display("FAIL %s done k=%0d got=%0b want=%0b", tag, k, done, (k == FRAME_CYCLES));
         end
         total++;
         if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy k=%0d got=%0b want=1", tag, k, busy);
         end
         if (k >= DIV) begin
            total++;
            if ({chip_a, chip_b, tx_level, bit_idx, chip_idx} !== hold) begin
               bad++;
               $display("FAIL %s chip_fields k=%0d got=%b want=%b", tag, k,
                        {chip_a, chip_b, tx_level, bit_idx, chip_idx}, hold);
            end
         end
      end
      $display("frame %s data=%b levels=%h chip_a=%b", tag, d, lv_seq, a_seq);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; auto_run = 1'b1; data = 4'hF;
      step();
      step();
      total++;
      if ({busy, chip_valid, tx_level, chip_a, chip_b, bit_idx, chip_idx, done} !== 11'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=0",
                  {busy, chip_valid, tx_level, chip_a, chip_b, bit_idx, chip_idx, done});
      end
      reset = 1'b0; start = 1'b0; auto_run = 1'b0;
      step();
      step();
      total++;
      if ({busy, chip_valid, done} !== 3'b000) begin
         bad++;
         $display("FAIL reset_idle got=%b want=000", {busy, chip_valid, done});
      end
      $display("reset checked");
   endtask

   task automatic test_patterns();
      logic [3:0]  pats [7];
      logic [23:0] lv;
      logic [7:0]  as;
      logic [23:0] want_lv;
      int          lv_0000 [8] = '{-2, 0, 0, 2, -2, 0, 0, 2};
      int          lv_1111 [8] = '{2, 0, 0, -2, 2, 0, 0, -2};
      // Bit 0 of each pair goes first: for 0110 user A sends ~code then code,
      // user B sends code then ~code.
      int          lv_0110 [8] = '{0, 2, -2, 0, 0, -2, 2, 0};
      pats[0] = 4'b0000;
      pats[1] = 4'b1111;
      pats[2] = 4'b0110;
      for (int i = 3; i < 7; i++) pats[i] = 4'($urandom_range(15, 0));
      for (int i = 0; i < 7; i++) begin
         data = pats[i]; start = 1'b1; auto_run = 1'b0;
         check_frame("pattern", pats[i], ~pats[i], 2, 0, 1'b0, lv, as);
         want_lv = '0;
         for (int j = 0; j < 8; j++) begin
            if (i == 0) want_lv[3*j +: 3] = 3'(lv_0000[j]);
            else if (i == 1) want_lv[3*j +: 3] = 3'(lv_1111[j]);
            else want_lv[3*j +: 3] = 3'(lv_0110[j]);
         end
         if (i < 3) begin
            total++;
            if (lv !== want_lv) begin
               bad++;
               $display("FAIL level_table data=%b got=%h want=%h", pats[i], lv, want_lv);
            end
         end
         if (i == 1) begin
            total++;
            if (as !== 8'b01010101) begin
               bad++;
               $display("FAIL chip_a_table data=1111 got=%b want=01010101", as);
            end
         end
         step();
         total++;
         if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL pattern_idle got=%b want=00", {busy, done});
         end
      end
   endtask

   task automatic test_start_held();
      logic [23:0] lv;
      logic [7:0]  as;
      logic [3:0]  d;
      d = 4'($urandom_range(15, 0));
      data = d; start = 1'b1; auto_run = 1'b0;
      check_frame("start_held", d, d, 0, 0, 1'b1, lv, as);
      step();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL start_held_busy_fall got=%0b want=0", busy);
      end
      step();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL start_held_second_accept got=%0b want=1", busy);
      end
      start = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [23:0] lv;
      logic [7:0]  as;
      logic [3:0]  d1, d2;
      d1 = 4'($urandom_range(15, 0));
      d2 = ~d1;
      data = d1; start = 1'b1; auto_run = 1'b1;
      check_frame("auto_first", d1, d2, 10, 0, 1'b0, lv, as);
      check_frame("auto_second", d2, d2, 0, 12, 1'b0, lv, as);
      step();
      total++;
      if ({busy, chip_valid, done} !== 3'b000) begin
         bad++;
         $display("FAIL auto_stop got=%b want=000", {busy, chip_valid, done});
      end
   endtask

   task automatic test_reset_midframe();
      logic [23:0] lv;
      logic [7:0]  as;
      logic [3:0]  d;
      data = 4'($urandom_range(15, 0)); start = 1'b1; auto_run = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (i == 1) start = 1'b0;
      end
      reset = 1'b1; start = 1'b1;
      step();
      total++;
      if ({busy, chip_valid, tx_level, chip_a, chip_b, bit_idx, chip_idx, done} !== 11'd0) begin
         bad++;
         $display("FAIL abort_outputs got=%b want=0",
                  {busy, chip_valid, tx_level, chip_a, chip_b, bit_idx, chip_idx, done});
      end
      reset = 1'b0; start = 1'b0;
      for (int i = 12; i <= 15; i++) begin
         step();
         total++;
         if ({busy, chip_valid, done} !== 3'b000) begin
            bad++;
            $display("FAIL abort_quiet cycle=%0d got=%b want=000", i, {busy, chip_valid, done});
         end
      end
      d = 4'($urandom_range(15, 0));
      data = d; start = 1'b1;
      check_frame("after_abort", d, d, 0, 0, 1'b0, lv, as);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_patterns();
      test_start_held();
      test_back_to_back();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
